// File: rtl/apple1_pkg.sv
// Shared definitions for the RAM dump block: FSM encoding and UART timing default.
package apple1_pkg;

  // 7.15909 MHz / 115200 baud, rounded
  localparam int BAUD_DIV_DEFAULT = 62;

  // start bit + 8 data bits + stop bit
  localparam int FRAME_BITS = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SEND   = 3'd3,
    ST_FINISH = 3'd4
  } dump_state_t;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 serializer: one byte per load pulse, LSB first, line idles high.
module uart_tx_8n1
  import apple1_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk7,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       idle
);

  localparam int            CW        = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [3:0]    STOP_BIT  = 4'(FRAME_BITS - 1);

  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          active_q, active_d;
  logic          last_tick;

  // Final cycle of the stop bit. Reporting idle here lets the sequencer start
  // the next read without inserting an extra high cycle between frames.
  assign last_tick = active_q && (baud_q == BAUD_LAST) && (bit_q == STOP_BIT);
  assign idle      = ~active_q | last_tick;
  assign tx        = tx_q;

  // Bit timing and shifting; a load starts the start bit on the following cycle
  always_comb begin
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    active_d = active_q;
    if (load) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = 4'd0;
      shift_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (baud_q == BAUD_LAST) begin
        baud_d = '0;
        if (bit_q == STOP_BIT) begin
          active_d = 1'b0;
          bit_d    = 4'd0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            tx_d = 1'b1;
          end
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  // Serializer registers; reset drives the line high immediately
  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 8'h00;
      tx_q     <= 1'b1;
      active_q <= 1'b0;
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/ram_dumper.sv
// Walks an inclusive RAM address range and streams each byte out over UART.
module ram_dumper
  import apple1_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk7,
  input  logic        rst_n,
  input  logic        clk_ena,
  input  logic        start,
  input  logic [15:0] start_addr,
  input  logic [15:0] end_addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] ram_addr,
  output logic        ram_rd,
  input  logic [7:0]  ram_dout,
  output logic        uart_tx
);

  dump_state_t state_q, state_d;
  logic [15:0] cur_addr_q, cur_addr_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic        tx_load;
  logic        tx_idle;

  uart_tx_8n1 #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk7 (clk7),
    .rst_n(rst_n),
    .load (tx_load),
    .data (ram_dout),
    .tx   (uart_tx),
    .idle (tx_idle)
  );

  // State register
  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Address registers
  always_ff @(posedge clk7) begin
    if (!rst_n) begin
      cur_addr_q  <= 16'h0000;
      last_addr_q <= 16'h0000;
    end else begin
      cur_addr_q  <= cur_addr_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Next-state and address sequencing; last address is tested before the
  // increment so a range ending at FFFF never wraps to 0000
  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    last_addr_d = last_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_addr_d  = start_addr;
          last_addr_d = end_addr;
          state_d     = (end_addr < start_addr) ? ST_FINISH : ST_READ;
        end
      end
      ST_READ: begin
        if (clk_ena) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (clk_ena) state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_idle) begin
          if (cur_addr_q == last_addr_q) begin
            state_d = ST_FINISH;
          end else begin
            cur_addr_d = cur_addr_q + 16'd1;
            state_d    = ST_READ;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state; the byte is handed to the
  // serializer on the clk_ena cycle where read data is valid
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    ram_rd  = 1'b0;
    tx_load = 1'b0;
    case (state_q)
      ST_READ: begin
        busy   = 1'b1;
        ram_rd = 1'b1;
      end
      ST_WAIT: begin
        busy    = 1'b1;
        tx_load = clk_ena;
      end
      ST_SEND:   busy = 1'b1;
      ST_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  assign ram_addr = cur_addr_q;

endmodule
